load_controller: RTL and testbench

- Read-side counterpart of the tile store path: fetches a tile (A or B operand) row by row from memory over the shared memory interface and writes each row into the four per-lane-group input buffers that feed the systolic array.
- A row of up to 16 32-bit words is split into up to four 16-byte chunks; chunk k goes to buffer k.
- One outstanding read at a time; the block stalls on per-buffer full flags and on interface ready/valid.

---
 rtl/load_controller.sv | 123 ++++++++++++
 tb/tb_load_controller.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_controller.sv
// Tile load path: fetches a tile row by row over the shared memory interface
// and scatters each row's 16-byte chunks into the per-lane-group input buffers.
module load_controller #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 128,
    parameter int NBUF   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              can_do_load,
    input  logic [ADDR_W-1:0] tile_addr,
    input  logic [ADDR_W-1:0] tile_stride,
    input  logic [4:0]        msize,
    input  logic [4:0]        nsize,
    input  logic [NBUF-1:0]   buffer_full,
    input  logic              interface_ready,
    input  logic              interface_rvalid,
    input  logic [DATA_W-1:0] interface_rdata,
    output logic              interface_en,
    output logic              interface_rdwr,
    output logic [4:0]        interface_control,
    output logic [ADDR_W-1:0] current_addr,
    output logic [NBUF-1:0]   wr_buffer,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done_load
);
    localparam int CW = $clog2(NBUF);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t            state;
    logic [ADDR_W-1:0] row_addr;
    logic [ADDR_W-1:0] stride;
    logic [4:0]        msize_r;
    logic [4:0]        nsat;
    logic [4:0]        row;
    logic [CW-1:0]     chunk;

    logic [4:0] nchunks;
    logic [4:0] words_left;
    logic [2:0] lane_cnt;
    logic       last_chunk;
    logic       last_row;
    logic       wr_fire;
    logic       start_empty;

    // Zero every 32-bit lane at or above the number of valid words.
    function automatic logic [DATA_W-1:0] mask_lanes(input logic [DATA_W-1:0] d,
                                                     input logic [2:0]        n);
        logic [DATA_W-1:0] m;
        m = d;
        for (int i = 0; i < DATA_W / 32; i++) begin
            if (i >= int'(n)) m[i*32 +: 32] = '0;
        end
        return m;
    endfunction

    always_comb begin
        nchunks     = (nsat + 5'd3) >> 2;
        words_left  = nsat - (5'(chunk) << 2);
        lane_cnt    = (words_left >= 5'd4) ? 3'd4 : words_left[2:0];
        last_chunk  = (5'(chunk) == nchunks - 5'd1);
        last_row    = (row == msize_r - 5'd1);
        wr_fire     = (state == WAIT) && interface_rvalid;
        start_empty = (state == IDLE) && can_do_load && ((msize == 5'd0) || (nsize == 5'd0));

        busy              = (state != IDLE);
        interface_rdwr    = 1'b0;
        interface_en      = (state == ISSUE) && !buffer_full[chunk];
        interface_control = busy ? {lane_cnt, 2'b00} : 5'd0;
        current_addr      = busy ? row_addr + (ADDR_W'(chunk) << 4) : '0;
        wr_buffer         = wr_fire ? (NBUF'(1) << chunk) : '0;
        wr_data           = wr_fire ? mask_lanes(interface_rdata, lane_cnt) : '0;
        // Gated by rst so no completion can be reported while reset is held.
        done_load         = !rst && (start_empty || (wr_fire && last_chunk && last_row));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            row_addr <= '0;
            stride   <= '0;
            msize_r  <= '0;
            nsat     <= '0;
            row      <= '0;
            chunk    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (can_do_load) begin
                        row_addr <= tile_addr;
                        stride   <= tile_stride;
                        msize_r  <= msize;
                        nsat     <= (nsize > 5'd16) ? 5'd16 : nsize;
                        row      <= '0;
                        chunk    <= '0;
                        if ((msize != 5'd0) && (nsize != 5'd0)) state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (interface_en && interface_ready) state <= WAIT;
                end
                WAIT: begin
                    if (interface_rvalid) begin
                        if (!last_chunk) begin
                            chunk <= chunk + CW'(1);
                            state <= ISSUE;
                        end else if (!last_row) begin
                            row      <= row + 5'd1;
                            chunk    <= '0;
                            row_addr <= row_addr + (stride << 2);
                            state    <= ISSUE;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_controller.sv
// Bench for load_controller: directed vector table, hand-written corner sequences
// and randomized traffic checked against a request/write list model.
module tb_load_controller;
    logic         clk = 1'b0;
    logic         rst;
    logic         can_do_load;
    logic [31:0]  tile_addr, tile_stride;
    logic [4:0]   msize, nsize;
    logic [3:0]   buffer_full;
    logic         interface_ready, interface_rvalid;
    logic [127:0] interface_rdata;
    logic         interface_en, interface_rdwr;
    logic [4:0]   interface_control;
    logic [31:0]  current_addr;
    logic [3:0]   wr_buffer;
    logic [127:0] wr_data;
    logic         busy, done_load;

    always #5 clk = ~clk;

    load_controller #(.ADDR_W(32), .DATA_W(128), .NBUF(4)) dut (
        .clk(clk), .rst(rst), .can_do_load(can_do_load), .tile_addr(tile_addr),
        .tile_stride(tile_stride), .msize(msize), .nsize(nsize), .buffer_full(buffer_full),
        .interface_ready(interface_ready), .interface_rvalid(interface_rvalid),
        .interface_rdata(interface_rdata), .interface_en(interface_en),
        .interface_rdwr(interface_rdwr), .interface_control(interface_control),
        .current_addr(current_addr), .wr_buffer(wr_buffer), .wr_data(wr_data),
        .busy(busy), .done_load(done_load)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [4:0]  ctrl;
        int          buf_i;
        int          words;
    } req_t;

    req_t exp_q[$];

    // Every request of a tile, in order, straight from the tile geometry.
    function automatic void build(input logic [31:0] a, input logic [31:0] s, input int m, input int n);
        int ns;
        ns = (n > 16) ? 16 : n;
        exp_q.delete();
        for (int r = 0; r < m; r++) begin
            for (int c = 0; c * 4 < ns; c++) begin
                req_t t;
                t.addr  = a + 32'(r) * s * 32'd4 + 32'(16 * c);
                t.words = ((ns - 4 * c) > 4) ? 4 : (ns - 4 * c);
                t.ctrl  = 5'(t.words * 4);
                t.buf_i = c;
                exp_q.push_back(t);
            end
        end
    endfunction

    function automatic logic [127:0] keep_words(input logic [127:0] d, input int words);
        if (words >= 4) return d;
        return d & ((128'(1) << (32 * words)) - 128'(1));
    endfunction

    // Traffic knobs and per-run observations.
    int ready_pct = 100, full_pct = 0, rv_max = 0, rv_fixed = -1, noise = 0;
    int stall_idx = -1, stall_len = 0, rlow_idx = -1, rlow_len = 0, abort_idx = -1;
    bit ones_data = 0;
    int r_reqs, r_cycles, r_stall_seen;
    logic [31:0]  r_last_addr;
    logic [4:0]   r_last_ctrl;
    logic [127:0] r_last_wdata;

    task automatic run_op(input logic [31:0] a, input logic [31:0] s, input int m, input int n,
                          input string tag);
        int idx, dly, cyc, stall_left, rlow_left;
        bit outst, fin, exp_en;
        req_t cur;
        build(a, s, m, n);
        r_reqs = 0; r_cycles = 0; r_stall_seen = 0;
        r_last_addr = '0; r_last_ctrl = '0; r_last_wdata = '0;
        @(negedge clk);
        can_do_load = 1'b1; tile_addr = a; tile_stride = s; msize = 5'(m); nsize = 5'(n);
        buffer_full = '0; interface_ready = 1'b0; interface_rvalid = 1'b0;
        #1;
        chk({tag, " start busy"}, busy, 0);
        chk({tag, " start en"}, interface_en, 0);
        chk({tag, " rdwr"}, interface_rdwr, 0);
        chk({tag, " start done"}, done_load, (m == 0 || n == 0) ? 1 : 0);
        if (m == 0 || n == 0) begin
            @(negedge clk);
            can_do_load = 1'b0;
            #1;
            chk({tag, " empty stays idle"}, busy, 0);
            return;
        end
        idx = 0; outst = 0; dly = 0; fin = 0;
        stall_left = stall_len; rlow_left = rlow_len;
        for (cyc = 1; cyc <= 4000 && !fin; cyc++) begin
            @(negedge clk);
            can_do_load = ($urandom_range(0, 3) == 0);
            tile_addr = $urandom; tile_stride = $urandom;
            msize = 5'($urandom); nsize = 5'($urandom);
            interface_rdata = ones_data ? '1 : {$urandom, $urandom, $urandom, $urandom};
            for (int b = 0; b < 4; b++) buffer_full[b] = ($urandom_range(0, 99) < full_pct);
            cur = exp_q[idx];
            if (outst && idx == abort_idx) begin
                interface_rvalid = 1'b1;
                rst = 1'b1;
                #1;
                chk({tag, " abort wr_buffer"}, wr_buffer, 0);
                chk({tag, " abort busy"}, busy, 0);
                chk({tag, " abort en"}, interface_en, 0);
                chk({tag, " abort done"}, done_load, 0);
                chk({tag, " abort addr"}, current_addr, 0);
                @(negedge clk);
                #1;
                chk({tag, " held reset done"}, done_load, 0);
                chk({tag, " held reset wr"}, wr_buffer, 0);
                rst = 1'b0; interface_rvalid = 1'b0; can_do_load = 1'b0;
                return;
            end
            if (!outst) begin
                interface_ready  = ($urandom_range(0, 99) < ready_pct);
                interface_rvalid = noise ? 1'($urandom) : 1'b0;
                if (idx == stall_idx && stall_left > 0) begin
                    buffer_full[cur.buf_i] = 1'b1;
                    stall_left--;
                end
                if (idx == rlow_idx && rlow_left > 0) begin
                    interface_ready = 1'b0;
                    rlow_left--;
                end
            end else begin
                interface_ready  = 1'($urandom);
                interface_rvalid = (dly == 0);
            end
            #1;
            chk({tag, " busy"}, busy, 1);
            if (!outst) begin
                exp_en = !buffer_full[cur.buf_i];
                chk({tag, " en"}, interface_en, exp_en);
                chk({tag, " issue wr_buffer"}, wr_buffer, 0);
                chk({tag, " issue done"}, done_load, 0);
                if (!exp_en && idx == stall_idx) r_stall_seen++;
                if (exp_en) begin
                    chk({tag, " addr"}, current_addr, cur.addr);
                    chk({tag, " ctrl"}, interface_control, cur.ctrl);
                    if (interface_ready) begin
                        outst = 1;
                        dly = (rv_fixed >= 0) ? rv_fixed : ((rv_max == 0) ? 0 : $urandom_range(0, rv_max));
                        r_reqs++;
                        r_last_addr = current_addr;
                        r_last_ctrl = interface_control;
                    end
                end
            end else begin
                chk({tag, " wait en"}, interface_en, 0);
                if (interface_rvalid) begin
                    chk({tag, " wr_buffer"}, wr_buffer, 4'(1) << cur.buf_i);
                    chk({tag, " wr_data"}, wr_data, keep_words(interface_rdata, cur.words));
                    chk({tag, " done"}, done_load, (idx == exp_q.size() - 1) ? 1 : 0);
                    r_last_wdata = wr_data;
                    idx++;
                    outst = 0;
                    if (idx == exp_q.size()) fin = 1;
                end else begin
                    chk({tag, " wait wr_buffer"}, wr_buffer, 0);
                    chk({tag, " wait done"}, done_load, 0);
                    dly--;
                end
            end
        end
        r_cycles = cyc - 1;
        if (!fin) begin
            checks++; errors++;
            $display("FAIL %s timeout: got %0d writes expected %0d", tag, idx, exp_q.size());
        end
        @(negedge clk);
        can_do_load = 1'b0; interface_rvalid = 1'b1; interface_ready = 1'b0; buffer_full = '0;
        #1;
        chk({tag, " end busy"}, busy, 0);
        chk({tag, " end en"}, interface_en, 0);
        chk({tag, " end done"}, done_load, 0);
        chk({tag, " end stray write"}, wr_buffer, 0);
        interface_rvalid = 1'b0;
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] s;
        int          m;
        int          n;
        int          reqs;
        logic [31:0] last_addr;
        logic [4:0]  last_ctrl;
        int          cyc;
    } vec_t;

    vec_t tbl[9];

    initial begin
        tbl[0] = '{32'h1000, 32'd16, 2, 16, 8, 32'h1070, 5'd16, 16};
        tbl[1] = '{32'h2000, 32'd5, 1, 6, 2, 32'h2010, 5'd8, 4};
        tbl[2] = '{32'h0000, 32'd1, 3, 4, 3, 32'h0008, 5'd16, 6};
        tbl[3] = '{32'h0100, 32'd8, 2, 20, 8, 32'h0150, 5'd16, 16};
        tbl[4] = '{32'hFFFF_FFF0, 32'd4, 2, 5, 4, 32'h0010, 5'd4, 8};
        tbl[5] = '{32'h3000, 32'd0, 2, 1, 2, 32'h3000, 5'd4, 4};
        tbl[6] = '{32'h4000, 32'd3, 31, 31, 124, 32'h4198, 5'd16, 248};
        tbl[7] = '{32'h5000, 32'd7, 0, 8, 0, 32'h0, 5'd0, 0};
        tbl[8] = '{32'h5000, 32'd7, 4, 0, 0, 32'h0, 5'd0, 0};

        rst = 1'b1; can_do_load = 1'b0; tile_addr = '0; tile_stride = '0; msize = '0; nsize = '0;
        buffer_full = '0; interface_ready = 1'b0; interface_rvalid = 1'b0; interface_rdata = '0;
        repeat (2) @(negedge clk);
        interface_rvalid = 1'b1; interface_ready = 1'b1; interface_rdata = '1;
        #1;
        chk("reset en", interface_en, 0);
        chk("reset addr", current_addr, 0);
        chk("reset ctrl", interface_control, 0);
        chk("reset wr_buffer", wr_buffer, 0);
        chk("reset wr_data", wr_data, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done_load, 0);
        @(negedge clk);
        rst = 1'b0; interface_rvalid = 1'b0; interface_ready = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_op(tbl[i].a, tbl[i].s, tbl[i].m, tbl[i].n, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d reqs", i), r_reqs, tbl[i].reqs);
            chk($sformatf("vec%0d last addr", i), r_last_addr, tbl[i].last_addr);
            chk($sformatf("vec%0d last ctrl", i), r_last_ctrl, tbl[i].last_ctrl);
            chk($sformatf("vec%0d cycles", i), r_cycles, tbl[i].cyc);
        end

        ones_data = 1;
        run_op(32'h2000, 32'd5, 1, 6, "ones");
        chk("ones tail lanes", r_last_wdata, {64'h0, {64{1'b1}}});
        ones_data = 0;

        stall_idx = 1; stall_len = 5;
        run_op(32'h6000, 32'd9, 3, 4, "stall");
        chk("stall cycles", r_stall_seen, 5);
        chk("stall reqs", r_reqs, 3);
        stall_idx = -1; stall_len = 0;

        rlow_idx = 0; rlow_len = 3; rv_fixed = 4;
        run_op(32'h7000, 32'd4, 1, 8, "slow");
        chk("slow cycles", r_cycles, 3 + 1 + 4 + 1 + 1 + 4 + 1);
        rlow_idx = -1; rlow_len = 0; rv_fixed = -1;

        abort_idx = 2;
        run_op(32'h8000, 32'd16, 3, 8, "abort");
        abort_idx = -1;
        run_op(32'h9000, 32'd2, 2, 8, "restart");
        chk("restart first addr", exp_q[0].addr, 32'h9000);
        chk("restart reqs", r_reqs, 4);

        ready_pct = 60; full_pct = 25; rv_max = 3; noise = 1;
        for (int i = 0; i < 25; i++) begin
            run_op($urandom, $urandom_range(0, 300), $urandom_range(0, 6), $urandom_range(0, 22),
                   $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
